// File: rtl/sid_waveform_mixer.sv
// rtl/sid_waveform_mixer.sv - SID voice waveform mixer with floating-DAC hold/fade and LFSR writeback
// wav_i packs {selector[3:0]=N,P,S,T, noise[7:0], pulse, saw_tri[11:0]}; model 0=MOS6581, 1=MOS8580.
module sid_waveform_mixer #(
    parameter logic [13:0] FADE_TTL_6581 = 14'd54,
    parameter logic [13:0] FADE_TTL_8580 = 14'd800,
    parameter int          PHI1          = 0
) (
    input  logic        clk,
    input  logic        res_n,
    input  logic        tick_ms,
    input  logic        model,
    input  logic [1:0]  phase,
    input  logic [24:0] wav_i,
    output logic [11:0] wav_o,
    output logic [7:0]  noise_wb,
    output logic        noise_we
);

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        HOLD   = 2'd1,
        FADED  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [11:0] wav_q, wav_d;
    logic [7:0]  noise_wb_q, noise_wb_d;
    logic        noise_we_q, noise_we_d;
    logic [13:0] cnt_q, cnt_d;
    logic        tick_pend_q, tick_pend_d;

    logic [3:0]  sel;
    logic [7:0]  noise;
    logic        pulse;
    logic [11:0] saw_tri;
    logic [11:0] mix;
    logic [13:0] cnt_inc;
    logic [13:0] ttl;
    logic        tick_eff;
    logic        we_next;

    always_comb begin
        sel     = wav_i[24:21];
        noise   = wav_i[20:13];
        pulse   = wav_i[12];
        saw_tri = wav_i[11:0];

        // Unselected components contribute all-ones so the AND only sees selected ones.
        mix = 12'hfff;
        if (sel[0]) mix = mix & {saw_tri[10:0], 1'b0};
        if (sel[1]) mix = mix & saw_tri;
        if (sel[2]) mix = mix & {12{pulse}};
        if (sel[3]) mix = mix & {noise, 4'b0000};

        tick_eff = tick_ms | tick_pend_q;
        cnt_inc  = (cnt_q == 14'h3fff) ? cnt_q : cnt_q + {13'd0, tick_eff};
        ttl      = model ? FADE_TTL_8580 : FADE_TTL_6581;
        we_next  = sel[3] & (|sel[2:0]);

        state_d     = state_q;
        wav_d       = wav_q;
        noise_wb_d  = noise_wb_q;
        noise_we_d  = noise_we_q;
        cnt_d       = cnt_q;
        tick_pend_d = tick_pend_q | tick_ms;

        if (phase[PHI1]) begin
            tick_pend_d = 1'b0;
            noise_we_d  = we_next;
            noise_wb_d  = we_next ? mix[11:4] : 8'hff;
            if (sel != 4'b0000) begin
                state_d = ACTIVE;
                wav_d   = mix;
                cnt_d   = 14'd0;
            end else begin
                case (state_q)
                    ACTIVE: state_d = HOLD;
                    HOLD: begin
                        cnt_d = cnt_inc;
                        // >= so a model switch to a shorter TTL expires at once.
                        if (cnt_inc >= ttl) begin
                            wav_d   = 12'd0;
                            state_d = FADED;
                        end
                    end
                    FADED:   wav_d   = 12'd0;
                    default: state_d = ACTIVE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q     <= ACTIVE;
            wav_q       <= 12'd0;
            noise_wb_q  <= 8'hff;
            noise_we_q  <= 1'b0;
            cnt_q       <= 14'd0;
            tick_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wav_q       <= wav_d;
            noise_wb_q  <= noise_wb_d;
            noise_we_q  <= noise_we_d;
            cnt_q       <= cnt_d;
            tick_pend_q <= tick_pend_d;
        end
    end

    assign wav_o    = wav_q;
    assign noise_wb = noise_wb_q;
    assign noise_we = noise_we_q;

endmodule

// File: tb/tb_sid_waveform_mixer.sv
// tb/tb_sid_waveform_mixer.sv - directed and randomized checks of sid_waveform_mixer against a behavioural model
// The model tracks "milliseconds spent floating" and the held DAC value directly.
module tb_sid_waveform_mixer;

    logic        clk = 1'b0;
    logic        res_n = 1'b0;
    logic        tick_ms = 1'b0;
    logic        model = 1'b0;
    logic [1:0]  phase = 2'b00;
    logic [24:0] wav_i = '0;
    logic [11:0] wav_o;
    logic [7:0]  noise_wb;
    logic        noise_we;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [11:0] m_wav;
    logic [7:0]  m_wb;
    logic        m_we;
    bit          m_floating;
    bit          m_faded;
    int          m_ms;
    bit          m_pend;

    sid_waveform_mixer dut (
        .clk      (clk),
        .res_n    (res_n),
        .tick_ms  (tick_ms),
        .model    (model),
        .phase    (phase),
        .wav_i    (wav_i),
        .wav_o    (wav_o),
        .noise_wb (noise_wb),
        .noise_we (noise_we)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".wav"}, wav_o, m_wav);
        chk({tag, ".we"}, {11'd0, noise_we}, {11'd0, m_we});
        chk({tag, ".wb"}, {4'd0, noise_wb}, {4'd0, m_wb});
    endtask

    task automatic model_reset();
        m_wav = 12'd0; m_wb = 8'hff; m_we = 1'b0;
        m_floating = 0; m_faded = 0; m_ms = 0; m_pend = 0;
    endtask

    function automatic int ttl_ms(input logic mdl);
        return mdl ? 800 : 54;
    endfunction

    // Reference: combine waveforms and apply the floating-DAC behaviour for one PHI1 strobe.
    task automatic model_strobe(input logic [3:0] sel, input logic [7:0] nz, input logic p,
                                input logic [11:0] st, input logic tk, input logic mdl);
        logic [11:0] comp [4];
        logic [11:0] mx;
        bit got_tick;
        comp[0] = st << 1;
        comp[1] = st;
        comp[2] = p ? 12'hfff : 12'h000;
        comp[3] = {nz, 4'h0};
        mx = 12'hfff;
        for (int k = 0; k < 4; k++)
            if (sel[k]) mx = mx & comp[k];
        got_tick = tk || m_pend;
        m_pend = 0;
        m_we = sel[3] && (sel[2:0] != 3'b000);
        m_wb = m_we ? mx[11:4] : 8'hff;
        if (sel != 4'b0000) begin
            m_wav = mx; m_floating = 0; m_faded = 0; m_ms = 0;
        end else if (!m_floating) begin
            m_floating = 1;
        end else if (!m_faded) begin
            if (got_tick && m_ms < 16383) m_ms++;
            if (m_ms >= ttl_ms(mdl)) begin
                m_wav = 12'd0; m_faded = 1;
            end
        end
    endtask

    // Called 1 time unit after a posedge; leaves us 1 time unit after the next posedge.
    task automatic strobe(input string tag, input logic [3:0] sel, input logic [7:0] nz,
                          input logic p, input logic [11:0] st, input logic tk);
        wav_i   = {sel, nz, p, st};
        tick_ms = tk;
        phase   = {$urandom_range(0, 1) == 1, 1'b1};
        @(posedge clk);
        #1;
        phase   = 2'b00;
        tick_ms = 1'b0;
        model_strobe(sel, nz, p, st, tk, model);
        check_model(tag);
    endtask

    task automatic idle(input string tag, input logic tk);
        logic [3:0] sel;
        sel     = 4'($urandom);
        wav_i   = {sel, 8'($urandom), 1'($urandom), 12'($urandom)};
        tick_ms = tk;
        phase   = {1'($urandom), 1'b0};
        @(posedge clk);
        #1;
        tick_ms = 1'b0;
        phase   = 2'b00;
        if (tk) m_pend = 1;
        check_model(tag);
    endtask

    initial begin
        model_reset();
        #12;
        chk("reset.wav", wav_o, 12'd0);
        chk("reset.wb", {4'd0, noise_wb}, 12'h0ff);
        chk("reset.we", {11'd0, noise_we}, 12'd0);
        res_n = 1'b1;
        @(posedge clk); #1;

        strobe("saw", 4'b0010, 8'h00, 1'b0, 12'hABC, 1'b0);
        chk("saw.exact", wav_o, 12'hABC);
        idle("saw.hold_no_phi1", 1'b0);
        chk("saw.still", wav_o, 12'hABC);
        strobe("tri", 4'b0001, 8'h00, 1'b0, 12'h801, 1'b0);
        chk("tri.exact", wav_o, 12'h002);
        strobe("sawtri", 4'b0011, 8'h00, 1'b0, 12'hFFF, 1'b0);
        chk("sawtri.exact", wav_o, 12'hFFE);
        strobe("np", 4'b1100, 8'hA5, 1'b1, 12'h000, 1'b0);
        chk("np.wav", wav_o, 12'hA50);
        chk("np.wb", {4'd0, noise_wb}, 12'h0A5);
        chk("np.we", {11'd0, noise_we}, 12'd1);
        strobe("np0", 4'b1100, 8'hA5, 1'b0, 12'h000, 1'b0);
        chk("np0.wav", wav_o, 12'h000);
        chk("np0.wb", {4'd0, noise_wb}, 12'h000);

        // MOS6581 fade, half the ticks arriving between strobes
        model = 1'b0;
        strobe("h81.set", 4'b0010, 8'h00, 1'b0, 12'h123, 1'b0);
        strobe("h81.enter", 4'b0000, 8'h00, 1'b0, 12'h000, 1'b0);
        for (int i = 1; i <= 53; i++) begin
            if (i % 2 == 0) begin
                idle("h81.idle", 1'b1);
                strobe("h81.tick", 4'b0000, 8'h00, 1'b0, 12'h000, 1'b0);
            end else begin
                strobe("h81.tick", 4'b0000, 8'h00, 1'b0, 12'h000, 1'b1);
            end
        end
        chk("h81.53", wav_o, 12'h123);
        strobe("h81.54", 4'b0000, 8'h00, 1'b0, 12'h000, 1'b1);
        chk("h81.54", wav_o, 12'h000);
        strobe("h81.react", 4'b0010, 8'h00, 1'b0, 12'h5A5, 1'b1);
        chk("h81.react", wav_o, 12'h5A5);

        // MOS8580 fade
        model = 1'b1;
        strobe("h85.enter", 4'b0000, 8'h00, 1'b0, 12'h000, 1'b0);
        for (int i = 1; i <= 799; i++)
            strobe("h85.tick", 4'b0000, 8'h00, 1'b0, 12'h000, 1'b1);
        chk("h85.799", wav_o, 12'h5A5);
        strobe("h85.800", 4'b0000, 8'h00, 1'b0, 12'h000, 1'b1);
        chk("h85.800", wav_o, 12'h000);

        // Model switch mid-HOLD expires immediately
        strobe("sw.set", 4'b0010, 8'h00, 1'b0, 12'h777, 1'b0);
        strobe("sw.enter", 4'b0000, 8'h00, 1'b0, 12'h000, 1'b0);
        for (int i = 1; i <= 100; i++)
            strobe("sw.tick", 4'b0000, 8'h00, 1'b0, 12'h000, 1'b1);
        chk("sw.held", wav_o, 12'h777);
        model = 1'b0;
        strobe("sw.expire", 4'b0000, 8'h00, 1'b0, 12'h000, 1'b0);
        chk("sw.expire", wav_o, 12'h000);

        // Asynchronous reset in HOLD
        strobe("ar.set", 4'b1010, 8'hFF, 1'b0, 12'hF3C, 1'b0);
        strobe("ar.enter", 4'b0000, 8'h00, 1'b0, 12'h000, 1'b0);
        for (int i = 0; i < 10; i++)
            strobe("ar.tick", 4'b0000, 8'h00, 1'b0, 12'h000, 1'b1);
        chk("ar.held", wav_o, 12'hF30);
        #2 res_n = 1'b0;
        #1;
        chk("ar.async_wav", wav_o, 12'h000);
        chk("ar.async_wb", {4'd0, noise_wb}, 12'h0ff);
        #2 res_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
        for (int i = 0; i < 80; i++)
            strobe("ar.after", 4'b0000, 8'h00, 1'b0, 12'h000, 1'b1);
        chk("ar.zero", wav_o, 12'h000);

        // Randomized episodes: activity, then floating runs long enough to reach either TTL branch
        for (int ep = 0; ep < 24; ep++) begin
            int run;
            for (int j = 0; j < 4; j++) begin
                logic [3:0] s;
                s = 4'($urandom_range(1, 15));
                strobe("rnd.act", s, 8'($urandom), 1'($urandom), 12'($urandom), 1'($urandom));
                if ($urandom_range(0, 3) == 0) idle("rnd.idle", 1'($urandom));
            end
            if ($urandom_range(0, 4) == 0) model = ~model;
            run = $urandom_range(0, 70);
            for (int j = 0; j < run; j++) begin
                if ($urandom_range(0, 5) == 0) idle("rnd.fidle", 1'($urandom_range(0, 3) != 0));
                if ($urandom_range(0, 30) == 0) model = ~model;
                strobe("rnd.float", 4'b0000, 8'($urandom), 1'($urandom), 12'($urandom),
                       1'($urandom_range(0, 3) != 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
